// File: rtl/tff_bank_arbiter_pkg.sv
// Shared definitions for the T flip-flop bank arbiter.
//   state_e   : arbiter FSM state encoding (IDLE / APPLY / GAP)
//   GAP_CNT_W : width of the quiet-gap counter (HOLD_CYC range 0..15)
package tff_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops with per-bit toggle enable.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears every bit
//   clr_i  : synchronous clear, wins over any toggle in the same cycle
//   t_en_i : per-bit toggle enable
//   q_o    : flip-flop outputs
module tff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] t_en_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // NOTE: q_d gets its default before any conditional override so no path
  // leaves it unassigned, which keeps this block free of inferred latches.
  always_comb begin
    q_d = q_q ^ t_en_i;
    if (clr_i) q_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter/sequencer in front of a shared T flip-flop bank.
// One requester is granted at a time; its mask toggles the bank for exactly
// one cycle (APPLY), then a quiet gap of HOLD_CYC cycles (GAP) follows.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   req   : level-sensitive request lines, one per requester
//   mask  : flattened toggle masks, slice i = mask[i*WIDTH +: WIDTH]
//   clr   : synchronous clear of the bank, has priority over a toggle
//   gnt   : one-hot grant, high during APPLY only
//   ack   : one-cycle pulse when the toggled value first appears on q
//   busy  : high in APPLY and GAP
//   q     : bank state
module tff_bank_arbiter
  import tff_bank_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] mask,
  input  logic                   clr,
  output logic [N_REQ-1:0]       gnt,
  output logic                   ack,
  output logic                   busy,
  output logic [WIDTH-1:0]       q
);

  localparam int PTR_W = $clog2(N_REQ);

  // The counter is loaded with HOLD_CYC-1 on entry to GAP and leaves GAP
  // on the cycle it reads zero, giving exactly HOLD_CYC GAP cycles.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    GAP_CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_e                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       winner_q;
  logic [PTR_W-1:0]       winner_d;
  logic                   found_d;
  logic [WIDTH-1:0]       mask_latch_q;
  logic [GAP_CNT_W-1:0]   gap_cnt_q;
  logic [N_REQ-1:0]       gnt_q;
  logic                   ack_q;
  logic [WIDTH-1:0]       t_en;

  // Search upward from the pointer with wrap-around; first set bit wins.
  always_comb begin
    winner_d = '0;
    found_d  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found_d && req[(int'(ptr_q) + k) % N_REQ]) begin
        found_d  = 1'b1;
        winner_d = PTR_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      winner_q     <= '0;
      // NOTE: the mask latch is reset along with the control state so a
      // toggle interrupted by reset can never leak into the bank later.
      mask_latch_q <= '0;
      gap_cnt_q    <= '0;
      gnt_q        <= '0;
      ack_q        <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q      <= APPLY;
            winner_q     <= winner_d;
            gnt_q        <= N_REQ'(1) << winner_d;
            mask_latch_q <= mask[int'(winner_d)*WIDTH +: WIDTH];
          end
        end
        APPLY: begin
          // The bank toggles on this same edge, so ack lines up with new q.
          ack_q <= 1'b1;
          gnt_q <= '0;
          ptr_q <= (winner_q == PTR_W'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
          if (HOLD_CYC > 0) begin
            state_q   <= GAP;
            gap_cnt_q <= GAP_LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) state_q   <= IDLE;
          else                 gap_cnt_q <= gap_cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign t_en = (state_q == APPLY) ? mask_latch_q : '0;

  tff_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (clr),
    .t_en_i (t_en),
    .q_o    (q)
  );

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = (state_q == APPLY) || (state_q == GAP);

endmodule
